// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helpers.
package cnn_pkg;

  localparam int CNN_DATA_W  = 16;
  localparam int CONV1_MAP_W = 18;
  localparam int CONV1_MAP_H = 18;

  // Signed maximum of two CNN_DATA_W samples.
  function automatic logic [CNN_DATA_W-1:0] smax(input logic [CNN_DATA_W-1:0] a,
                                                 input logic [CNN_DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: one registered write port, one asynchronous read port.
// Contents are not reset; every entry is written in an even row before the
// odd row reads it.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH  = CONV1_MAP_W / 2,
  parameter int DATA_W = CNN_DATA_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_in,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the even-row pair maximum for this column pair.
  always_ff @(posedge clk_in) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool2.sv
// Streaming ReLU + 2x2/stride-2 max-pool stage behind the conv adder.
// Even rows fold each column pair into the line buffer; odd rows fold the
// column pair with the buffered value and emit one pooled sample.
module relu_maxpool2
  import cnn_pkg::*;
#(
  parameter int MAP_W  = CONV1_MAP_W,
  parameter int MAP_H  = CONV1_MAP_H,
  parameter int DATA_W = CNN_DATA_W,
  localparam int CW    = (MAP_W > 1) ? $clog2(MAP_W) : 1,
  localparam int RW    = (MAP_H > 1) ? $clog2(MAP_H) : 1,
  localparam int LB_D  = MAP_W / 2,
  localparam int AW    = (LB_D > 1) ? $clog2(LB_D) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_wr,
  output logic              map_done,
  output logic [CW-1:0]     col_idx,
  output logic [RW-1:0]     row_idx
);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] pool_out_q, pool_out_d;
  logic              pool_wr_q, pool_wr_d;
  logic              map_done_q, map_done_d;

  logic [DATA_W-1:0] relu;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] lb_rdata;
  logic [AW-1:0]     lb_idx;
  logic              lb_we;
  logic              last_col, last_row;

  // Negative samples (including the most negative code) clamp to zero.
  assign relu     = din[DATA_W-1] ? '0 : din;
  assign pair_max = max2(hold_q, relu);
  assign lb_idx   = AW'(col_q >> 1);
  assign last_col = (col_q == CW'(MAP_W - 1));
  assign last_row = (row_q == RW'(MAP_H - 1));

  pool_line_buf #(
    .DEPTH  (LB_D),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_line_buf (
    .clk_in  (clk_in),
    .we_i    (lb_we),
    .waddr_i (lb_idx),
    .wdata_i (pair_max),
    .raddr_i (lb_idx),
    .rdata_o (lb_rdata)
  );

  // Next state: raster counters, hold register, pool output on the window's last pixel.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    hold_d     = hold_q;
    pool_out_d = pool_out_q;
    pool_wr_d  = 1'b0;
    map_done_d = 1'b0;
    lb_we      = 1'b0;
    if (din_valid) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) row_d = last_row ? '0 : row_q + RW'(1);
      if (!col_q[0]) begin
        hold_d = relu;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        pool_out_d = max2(lb_rdata, pair_max);
        pool_wr_d  = 1'b1;
        map_done_d = last_col && last_row;
      end
    end
  end

  // State registers with synchronous active-low reset; reset wins over din_valid.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      pool_out_q <= '0;
      pool_wr_q  <= 1'b0;
      map_done_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      pool_out_q <= pool_out_d;
      pool_wr_q  <= pool_wr_d;
      map_done_q <= map_done_d;
    end
  end

  assign pool_out = pool_out_q;
  assign pool_wr  = pool_wr_q;
  assign map_done = map_done_q;
  assign col_idx  = col_q;
  assign row_idx  = row_q;

endmodule
